iter_divider: RTL and testbench

Multi-cycle radix-2 restoring integer divider for the EXE stage. It accepts one signed or unsigned division at a time over a valid/ready request port. It returns quotient and remainder over a valid/ready response port after a fixed iteration count. EXE drives it as the division responder: EXE holds its instruction until `out_valid`, then selects `quotient` for div and `remainder` for mod.

---
 rtl/iter_divider_if.sv | 30 +++
 rtl/iter_divider.sv | 118 +++++++++++
 tb/tb_iter_divider.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/iter_divider_if.sv
// Request/response bundle for the iterative divider.
// master = EXE side, slave = divider.
interface iter_divider_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic             in_flush;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output in_valid, in_signed, in_flush,
    output src1, src2, out_ready,
    input  in_ready, out_valid,
    input  quotient, remainder
  );

  modport slave (
    input  in_valid, in_signed, in_flush,
    input  src1, src2, out_ready,
    output in_ready, out_valid,
    output quotient, remainder
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider, WIDTH cycles per op.
// Ports: clk, reset (sync, high), bus (slave side).
module iter_divider #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  iter_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] raw_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dz_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] remo_q;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   t;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dq_step;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = remo_q;

  assign accept = bus.in_valid & (state_q == IDLE)
                & ~bus.in_flush;
  assign last   = (cnt_q == CW'(WIDTH - 1));

  // Most-negative input maps to 2^(W-1) unsigned.
  assign a_mag = (bus.in_signed & bus.src1[WIDTH-1])
               ? -bus.src1 : bus.src1;
  assign b_mag = (bus.in_signed & bus.src2[WIDTH-1])
               ? -bus.src2 : bus.src2;

  // Trial subtract; t[WIDTH] set means negative.
  assign t        = {rem_q, dq_q[WIDTH-1]}
                  - {1'b0, dvs_q};
  assign q_bit    = ~t[WIDTH];
  assign rem_step = q_bit ? t[WIDTH-1:0]
                  : {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};
  assign dq_step  = {dq_q[WIDTH-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.in_flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dq_q   <= '0;
      dvs_q  <= '0;
      raw_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      quo_q  <= '0;
      remo_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dq_q   <= a_mag;
      dvs_q  <= b_mag;
      raw_q  <= bus.src1;
      qneg_q <= bus.in_signed
              & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
      rneg_q <= bus.in_signed & bus.src1[WIDTH-1];
      dz_q   <= (bus.src2 == '0);
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 1'b1;
      rem_q <= rem_step;
      dq_q  <= dq_step;
      if (last && !bus.in_flush) begin
        if (dz_q) begin
          quo_q  <= '1;
          remo_q <= raw_q;
        end else begin
          quo_q  <= qneg_q ? -dq_step : dq_step;
          remo_q <= rneg_q ? -rem_step : rem_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider (WIDTH=32).
// Stimulus pushes expectations; monitor pops.
module tb_iter_divider;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   nres = 0;
  bit   ov_prev = 1'b0;
  exp_t sb[$];

  iter_divider_if #(.WIDTH(W)) bus ();

  iter_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [W-1:0] act,
                     logic [W-1:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               name, act, req);
    end
  endtask

  // Monitor: compare on each rising out_valid.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (bus.out_valid && !ov_prev) begin
        nres++;
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_result: q=%h r=%h",
                   bus.quotient, bus.remainder);
        end else begin
          e = sb.pop_front();
          chk("quotient", bus.quotient, e.q);
          chk("remainder", bus.remainder, e.r);
          chk("latency", W'(cyc), W'(e.cyc));
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  task automatic issue(bit s, logic [W-1:0] a,
                       logic [W-1:0] b,
                       logic [W-1:0] eq,
                       logic [W-1:0] er);
    exp_t e;
    int k;
    @(negedge clk);
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.src1      = a;
    bus.src2      = b;
    e.q   = eq;
    e.r   = er;
    e.cyc = cyc + W + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    nchk++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL timeout: %0d results pending",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!bus.out_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    nchk++;
    if (!bus.out_valid) begin
      nerr++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  initial begin
    logic [W-1:0] hq, hr;
    int r0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_flush  = 1'b0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_in_ready", W'(bus.in_ready), 1);
    chk("rst_out_valid", W'(bus.out_valid), 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);

    // 100/7 with consumer stalling 3 cycles.
    bus.out_ready = 1'b0;
    issue(0, 100, 7, 14, 2);
    wait_valid();
    hq = bus.quotient;
    hr = bus.remainder;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", W'(bus.out_valid), 1);
      chk("hold_q", bus.quotient, hq);
      chk("hold_r", bus.remainder, hr);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ack_valid", W'(bus.out_valid), 0);
    chk("ack_ready", W'(bus.in_ready), 1);
    wait_empty();

    issue(1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD,
          32'hFFFF_FFFF);
    wait_empty();
    issue(1, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1);
    wait_empty();
    issue(0, 32'hFFFF_FFF9, 2, 32'h7FFF_FFFC, 1);
    wait_empty();
    issue(1, 32'hFFFF_FFFB, 0, 32'hFFFF_FFFF,
          32'hFFFF_FFFB);
    wait_empty();
    issue(0, 9, 0, 32'hFFFF_FFFF, 9);
    wait_empty();
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 0);
    wait_empty();
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF,
          0, 32'h8000_0000);
    wait_empty();

    // Flush at CALC cycle 10: no result.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_signed = 1'b0;
    bus.src1      = 1000;
    bus.src2      = 3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.in_flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_in_ready", W'(bus.in_ready), 1);
    chk("flush_out_valid", W'(bus.out_valid), 0);
    @(negedge clk);
    bus.in_flush = 1'b0;
    repeat (40) @(negedge clk);
    issue(0, 50, 5, 10, 0);
    wait_empty();

    // Flush with valid in IDLE: no accept.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_flush = 1'b1;
    bus.src1     = 8;
    bus.src2     = 2;
    @(negedge clk);
    chk("flush_idle_ready", W'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b0;
    repeat (40) @(negedge clk);

    // Reset while in DONE.
    bus.out_ready = 1'b0;
    issue(0, 20, 3, 6, 2);
    wait_valid();
    wait_empty();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_done_valid", W'(bus.out_valid), 0);
    chk("rst_done_ready", W'(bus.in_ready), 1);
    reset = 1'b0;
    bus.out_ready = 1'b1;

    // in_valid held through CALC: one accept only.
    bus.out_ready = 1'b0;
    r0 = nres;
    issue(0, 77, 7, 11, 0);
    bus.in_valid = 1'b1;
    wait_valid();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_empty();
    repeat (40) @(negedge clk);
    chk("single_result", W'(nres - r0), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
